// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the UART transmit frame controller.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator for one UART frame; present only when UART_TX_PARITY_EN is defined.
// par_type selects even (PAR_EVEN) or odd (PAR_ODD) parity over data.
`ifdef UART_TX_PARITY_EN
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  par_bit
);

  always_comb begin
    par_bit = (^data) ^ (par_type == PAR_ODD);
  end

endmodule
`endif

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start bit, DATA_WIDTH bits from an external
// serializer, optional parity bit (macro UART_TX_PARITY_EN), stop bit.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_TYP,
`endif
  input  logic                  Ser_data,
  input  logic                  Ser_done,
  output logic                  Ser_en,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d, par_calc;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_DATA),
    .par_type(PAR_TYP),
    .par_bit (par_calc)
  );
`else
  logic unused_p_data;
  assign unused_p_data = ^P_DATA;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Data_Valid ? START : IDLE;
      START:   state_d = DATA;
      DATA: begin
        if (Ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY:  state_d = STOP;
`endif
      STOP:    state_d = Data_Valid ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // START is only entered on an accepted Data_Valid, so that is when parity is captured.
  always_comb begin
    par_d = par_q;
    if (state_d == START) begin
      par_d = par_calc;
    end else begin
      par_d = par_q;
    end
  end
`endif

  // Line level and Busy are decided one cycle early so they leave flops directly.
  always_comb begin
    tx_d   = STOP_BIT;
    busy_d = 1'b0;
    case (state_d)
      IDLE: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
      end
      START: begin
        tx_d   = START_BIT;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d   = par_q;
        busy_d = 1'b1;
      end
`endif
      STOP: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    Ser_en = 1'b0;
    case (state_q)
      START:   Ser_en = 1'b1;
      DATA:    Ser_en = ~Ser_done;
      default: Ser_en = 1'b0;
    endcase
  end

  // Data bits bypass the output flop so the serializer's bit appears in its own cycle.
  always_comb begin
    TX_OUT = (state_q == DATA) ? Ser_data : tx_q;
  end

  assign Busy = busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl with a behavioural serializer;
// frame lengths and parity follow the UART_TX_PARITY_EN build option.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL      = 11;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int FL      = 10;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Data_Valid = 1'b0;
  logic [DW-1:0] P_DATA = '0;
`ifdef UART_TX_PARITY_EN
  logic          PAR_TYP = 1'b0;
`endif
  logic          Ser_data, Ser_done, Ser_en, TX_OUT, Busy;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
`ifdef UART_TX_PARITY_EN
    .PAR_TYP   (PAR_TYP),
`endif
    .Ser_data  (Ser_data),
    .Ser_done  (Ser_done),
    .Ser_en    (Ser_en),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  // Serializer: loads when the controller can accept, presents one bit per Ser_en.
  int            ser_cnt = DW;
  logic [DW-1:0] ser_sh  = '0;
  logic          ser_bit = 1'b1;
  assign Ser_data = ser_bit;
  assign Ser_done = (ser_cnt == DW);

  always @(posedge CLK) begin
    if (RST) begin
      ser_cnt <= DW;
      ser_sh  <= '0;
      ser_bit <= 1'b1;
    end else if (Data_Valid && (!Busy || ser_cnt == DW)) begin
      ser_sh  <= P_DATA;
      ser_cnt <= 0;
    end else if (Ser_en && ser_cnt < DW) begin
      ser_bit <= ser_sh[0];
      ser_sh  <= ser_sh >> 1;
      ser_cnt <= ser_cnt + 1;
    end
  end

  typedef struct {
    logic        rst;
    logic        dv;
    logic [7:0]  data;
    logic        typ;
    logic        tx;
    logic        busy;
    logic        sen;
    string       name;
  } cyc_t;

  typedef struct {
    logic [7:0]  d;
    logic        t;
    logic [10:0] bits;
    int          gap;
    string       name;
  } vec_t;

  cyc_t cq[$];
  vec_t tbl[6];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [10:0] model_bits(input logic [7:0] d, input logic t);
    logic [10:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[i+1] = d[i];
    if (HAS_PAR) b[DW+1] = (^d) ^ t;
    return b;
  endfunction

  task automatic push_idle(input int n, input string name);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b0; c.dv = 1'b0; c.data = 8'($urandom); c.typ = 1'($urandom);
      c.tx = 1'b1; c.busy = 1'b0; c.sen = 1'b0; c.name = name;
      cq.push_back(c);
    end
  endtask

  // Frame cycle j: 0 start, 1..DW data, then parity (if built) and stop.
  task automatic push_frame(input logic [7:0] d, input logic t, input logic [10:0] bits,
                            input int gap, input bit noise, input int rst_at, input string name);
    cyc_t c;
    int   last;
    if (gap > 0) push_idle(gap, name);
    last = cq.size() - 1;
    cq[last].dv   = 1'b1;
    cq[last].data = d;
    cq[last].typ  = t;
    for (int j = 0; j < FL; j++) begin
      if (rst_at >= 0 && j > rst_at) break;
      c.rst  = (j == rst_at);
      c.dv   = noise && (j < DW) && ($urandom_range(0, 2) == 0) && !c.rst;
      c.data = 8'($urandom);
      c.typ  = 1'($urandom);
      c.tx   = bits[j];
      c.busy = 1'b1;
      c.sen  = (j < DW);
      c.name = name;
      cq.push_back(c);
    end
  endtask

  task automatic check(input string nm, input int cyc, input string sig,
                       input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s cycle %0d: got %b expected %b", nm, sig, cyc, act, exp);
    end
  endtask

  initial begin
    int base;
`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 1'b0, 11'h54A, 2, "a5_even"};
    tbl[1] = '{8'h00, 1'b1, 11'h600, 1, "00_odd"};
    tbl[2] = '{8'hFF, 1'b0, 11'h5FE, 1, "ff_even"};
    tbl[3] = '{8'h01, 1'b0, 11'h602, 0, "01_b2b"};
    tbl[4] = '{8'h81, 1'b0, 11'h502, 2, "81_even"};
    tbl[5] = '{8'h3C, 1'b1, 11'h678, 0, "3c_odd_b2b"};
`else
    tbl[0] = '{8'hA5, 1'b0, 11'h34A, 2, "a5"};
    tbl[1] = '{8'h00, 1'b0, 11'h200, 1, "00"};
    tbl[2] = '{8'hFF, 1'b0, 11'h3FE, 1, "ff"};
    tbl[3] = '{8'h01, 1'b0, 11'h202, 0, "01_b2b"};
    tbl[4] = '{8'h81, 1'b0, 11'h302, 2, "81"};
    tbl[5] = '{8'h3C, 1'b0, 11'h278, 0, "3c_b2b"};
`endif

    // Reset state, then directed table frames.
    push_idle(1, "reset_state");
    cq[0].rst = 1'b1;
    push_idle(2, "idle");
    for (int i = 0; i < 6; i++)
      push_frame(tbl[i].d, tbl[i].t, tbl[i].bits, tbl[i].gap, 1'b0, -1, tbl[i].name);
    push_idle(2, "idle_after_tbl");

    // Data_Valid with 0x3C in the middle of frame 0x81 must be ignored.
    push_frame(8'h81, 1'b0, model_bits(8'h81, 1'b0), 1, 1'b0, -1, "ignore_dv");
    base = cq.size() - FL;
    cq[base + 3].dv   = 1'b1;
    cq[base + 3].data = 8'h3C;
    push_idle(4, "no_second_frame");

    // Reset in the 4th data cycle, then a fresh Data_Valid is required.
    push_frame(8'h5A, 1'b1, model_bits(8'h5A, 1'b1), 1, 1'b0, 4, "rst_mid");
    push_idle(4, "after_rst_idle");
    push_frame(8'hC3, 1'b0, model_bits(8'hC3, 1'b0), 1, 1'b0, -1, "after_rst_frame");

    // Random frames, gaps and ignored Data_Valid pulses against the model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       t;
      d = 8'($urandom);
      t = 1'($urandom);
      push_frame(d, t, model_bits(d, t), $urandom_range(0, 3), 1'b1, -1, "random");
    end
    push_idle(3, "final_idle");

    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < cq.size(); k++) begin
      RST        = cq[k].rst;
      Data_Valid = cq[k].dv;
      P_DATA     = cq[k].data;
`ifdef UART_TX_PARITY_EN
      PAR_TYP    = cq[k].typ;
`endif
      @(negedge CLK);
      check(cq[k].name, k, "TX_OUT", TX_OUT, cq[k].tx);
      check(cq[k].name, k, "Busy",   Busy,   cq[k].busy);
      check(cq[k].name, k, "Ser_en", Ser_en, cq[k].sen);
      @(posedge CLK);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
